// File: rtl/vram_reader_pkg.sv
// Shared types and constants for the VRAM frame reader.
// Optional feature macro: VRAM_READER_CHECKSUM_EN (adds the CSUM state).
package vram_reader_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
`ifdef VRAM_READER_CHECKSUM_EN
        ,
        S_CSUM  = 2'd3
`endif
    } state_t;

    // Output buffer depth; also the cap on buffered + in-flight reads.
    localparam int BUF_DEPTH = 2;

    // 40x25 text screen.
    localparam int DEFAULT_FRAME_LEN = 1000;

endpackage

// File: rtl/vram_skid_buffer.sv
// Two-entry fall-through valid/ready buffer between the RAM read port and
// the byte stream. An incoming word is passed straight through when the
// buffer is empty and the consumer is ready; otherwise it is stored.
// Occupancy is exported so the reader can throttle read issue.
module vram_skid_buffer
    import vram_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             push;
    logic             pop;

    assign out_valid = (count != 2'd0) || in_valid;
    assign out_data  = (count != 2'd0) ? mem[rd_ptr] : (in_valid ? in_data : '0);
    assign pop       = out_ready && (count != 2'd0);
    assign push      = in_valid && !((count == 2'd0) && out_ready);

    // Storage array; contents are don't-care while the entry is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_frame_reader.sv
// Read-side frame sequencer for the snooped VRAM. On start it walks
// FRAME_LEN consecutive addresses (wrapping at 2**ADDR_WIDTH) through the
// synchronous RAM read port and streams the words out.
// Optional feature macro: VRAM_READER_CHECKSUM_EN appends a sum beat.
//
// Stream handshake: a beat transfers on any cycle where out_valid and
// out_ready are both high; once out_valid rises it stays high with
// out_data/out_last unchanged until that transfer happens.
module vram_frame_reader
    import vram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int FRAME_LEN  = DEFAULT_FRAME_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    localparam logic [ADDR_WIDTH:0]   LAST_IDX = (ADDR_WIDTH+1)'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH:0]   issue_cnt;   // reads issued this frame
    logic [ADDR_WIDTH:0]   beat_cnt;    // data beats accepted this frame
    logic                  inflight;    // read_q carries a word this cycle
    logic [1:0]            buf_count;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_ready;
    logic                  start_ok;
    logic                  issue;
    logic                  data_fire;
    logic                  last_data;
`ifdef VRAM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
`endif

    // A start in the done cycle is dropped so back-to-back frames need a gap.
    assign start_ok  = (state == S_IDLE) && start && !done;
    assign issue     = (state == S_RUN) &&
                       (({1'b0, buf_count} + {2'b00, inflight}) < 3'(BUF_DEPTH));
    assign last_data = (beat_cnt == LAST_IDX);
`ifdef VRAM_READER_CHECKSUM_EN
    assign buf_ready = out_ready && (state != S_CSUM);
`else
    assign buf_ready = out_ready;
`endif
    assign data_fire = buf_valid && buf_ready;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    vram_skid_buffer #(.WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight),
        .in_data   (read_q),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .out_ready (buf_ready),
        .count     (buf_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state and stream outputs.
    always_comb begin
        state_nx  = state;
        out_valid = buf_valid;
        out_data  = buf_data;
`ifdef VRAM_READER_CHECKSUM_EN
        out_last  = 1'b0;
`else
        out_last  = buf_valid && last_data;
`endif
        case (state)
            S_IDLE:  if (start_ok) state_nx = S_RUN;
            S_RUN:   if (issue && (issue_cnt == LAST_IDX)) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (data_fire && last_data) begin
`ifdef VRAM_READER_CHECKSUM_EN
                    state_nx = S_CSUM;
`else
                    state_nx = S_IDLE;
`endif
                end
            end
`ifdef VRAM_READER_CHECKSUM_EN
            S_CSUM: begin
                out_valid = 1'b1;
                out_data  = sum_q;
                out_last  = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // Address walk, frame counters, read-in-flight flag and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_addr <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
            done      <= 1'b0;
`ifdef VRAM_READER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            inflight <= issue;
            done     <= (state != S_IDLE) && (state_nx == S_IDLE);
            if (start_ok) begin
                read_addr <= base_addr;
                issue_cnt <= '0;
                beat_cnt  <= '0;
`ifdef VRAM_READER_CHECKSUM_EN
                sum_q     <= '0;
`endif
            end else begin
                if (issue) begin
                    read_addr <= read_addr + ADDR_ONE;
                    issue_cnt <= issue_cnt + CNT_ONE;
                end
                if (data_fire) begin
                    beat_cnt <= beat_cnt + CNT_ONE;
`ifdef VRAM_READER_CHECKSUM_EN
                    sum_q    <= sum_q + buf_data;
`endif
                end
            end
        end
    end

endmodule
